// File: rtl/id_ex_stage_if.sv
// ID -> EX handshake, decoded payload, EX-stage register outputs and stall statistics.
interface id_ex_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [3:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [15:0] load_use_stalls;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, ex_ready, flush,
    input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           load_use_stalls
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, ex_ready, flush,
    output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           load_use_stalls
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating stall counter.
// 1-cycle latency; holds when ex_ready=0, refuses ID on flush, load-use hazard or a full EX slot.
module id_ex_stage (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_payload_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  ex_payload_t id_d;
  ex_payload_t ex_q;
  logic        ex_valid_q;
  logic [15:0] stalls_q;
  logic        hz;
  logic        transfer;

  assign id_d = '{
    pc:         bus.id_pc,
    rs1_data:   bus.id_rs1_data,
    rs2_data:   bus.id_rs2_data,
    imm:        bus.id_imm,
    rs1:        bus.id_rs1,
    rs2:        bus.id_rs2,
    rd:         bus.id_rd,
    alu_op:     bus.id_alu_op,
    reg_write:  bus.id_reg_write,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    mem_to_reg: bus.id_mem_to_reg
  };

  // A load in EX whose result the ID instruction needs; x0 never carries a dependency.
  assign hz = ex_valid_q && ex_q.mem_read && (ex_q.rd != 5'd0) &&
              ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));

  assign bus.id_ready = !bus.flush && !hz && (!ex_valid_q || bus.ex_ready);
  assign transfer     = bus.id_valid && bus.id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      stalls_q   <= '0;
    end else begin
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (transfer) begin
        ex_valid_q <= 1'b1;
        ex_q       <= id_d;
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end

      if (bus.id_valid && hz && !bus.flush && (stalls_q != STALL_MAX)) begin
        stalls_q <= stalls_q + 16'd1;
      end
    end
  end

  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.ex_rs1_data     = ex_q.rs1_data;
  assign bus.ex_rs2_data     = ex_q.rs2_data;
  assign bus.ex_imm          = ex_q.imm;
  assign bus.ex_rs1          = ex_q.rs1;
  assign bus.ex_rs2          = ex_q.rs2;
  assign bus.ex_rd           = ex_q.rd;
  assign bus.ex_alu_op       = ex_q.alu_op;
  // Bubbles must never look like writes to forwarding or write-enable logic downstream.
  assign bus.ex_reg_write    = ex_q.reg_write  && ex_valid_q;
  assign bus.ex_mem_read     = ex_q.mem_read   && ex_valid_q;
  assign bus.ex_mem_write    = ex_q.mem_write  && ex_valid_q;
  assign bus.ex_mem_to_reg   = ex_q.mem_to_reg && ex_valid_q;
  assign bus.load_use_stalls = stalls_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, directed multi-cycle corners, then random traffic vs a reference model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2;
    logic [3:0]  alu_op;
    logic        rw, mr, mw, mtr;
  } instr_t;

  typedef struct {
    instr_t      ins;
    bit          v, er;
    bit          exp_rdy, exp_valid;
    logic [31:0] exp_pc;
    bit          exp_rw;
    int          exp_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the instruction sitting in EX, its liveness, and the stall tally.
  bit     m_valid;
  instr_t m_ins;
  int     m_cnt;
  bit     seen_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input bit u1, input bit u2, input bit rw, input bit mr);
    instr_t i;
    i.pc = pc; i.rs1_data = pc ^ 32'hA5A5_0000; i.rs2_data = ~pc; i.imm = pc + 32'd100;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.use1 = u1; i.use2 = u2;
    i.alu_op = pc[5:2]; i.rw = rw; i.mr = mr; i.mw = 1'b0; i.mtr = mr;
    return i;
  endfunction

  function automatic vec_t mkv(input instr_t ins, input bit v, input bit er, input bit exp_rdy,
                               input bit exp_valid, input logic [31:0] exp_pc, input bit exp_rw, input int exp_cnt);
    vec_t t;
    t.ins = ins; t.v = v; t.er = er; t.exp_rdy = exp_rdy; t.exp_valid = exp_valid;
    t.exp_pc = exp_pc; t.exp_rw = exp_rw; t.exp_cnt = exp_cnt;
    return t;
  endfunction

  function automatic bit model_hz(input instr_t i);
    return m_valid && m_ins.mr && (m_ins.rd != 0) &&
           ((i.use1 && i.rs1 == m_ins.rd) || (i.use2 && i.rs2 == m_ins.rd));
  endfunction

  task automatic check_outputs();
    check("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
    check("ex_pc", 64'(bus.ex_pc), 64'(m_ins.pc));
    check("ex_rs1_data", 64'(bus.ex_rs1_data), 64'(m_ins.rs1_data));
    check("ex_rs2_data", 64'(bus.ex_rs2_data), 64'(m_ins.rs2_data));
    check("ex_imm", 64'(bus.ex_imm), 64'(m_ins.imm));
    check("ex_idx", 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}), 64'({m_ins.rs1, m_ins.rs2, m_ins.rd}));
    check("ex_alu_op", 64'(bus.ex_alu_op), 64'(m_ins.alu_op));
    check("ex_ctrl", 64'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
          m_valid ? 64'({m_ins.rw, m_ins.mr, m_ins.mw, m_ins.mtr}) : 64'd0);
    check("load_use_stalls", 64'(bus.load_use_stalls), 64'(m_cnt));
  endtask

  // One clock: drive inputs, check combinational ready, advance the model, check registered outputs.
  task automatic cycle(input instr_t i, input bit v, input bit er, input bit fl, input bit r, input bit chk);
    bit exp_rdy, hz;
    bus.id_valid = v; bus.ex_ready = er; bus.flush = fl; rst = r;
    bus.id_pc = i.pc; bus.id_rs1_data = i.rs1_data; bus.id_rs2_data = i.rs2_data; bus.id_imm = i.imm;
    bus.id_rs1 = i.rs1; bus.id_rs2 = i.rs2; bus.id_rd = i.rd;
    bus.id_use_rs1 = i.use1; bus.id_use_rs2 = i.use2; bus.id_alu_op = i.alu_op;
    bus.id_reg_write = i.rw; bus.id_mem_read = i.mr; bus.id_mem_write = i.mw; bus.id_mem_to_reg = i.mtr;
    #1;
    hz = model_hz(i);
    exp_rdy = !fl && !hz && (!m_valid || er);
    seen_rdy = bus.id_ready;
    if (chk) check("id_ready", 64'(bus.id_ready), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_ins = '0; m_cnt = 0;
    end else begin
      if (v && hz && !fl && m_cnt < 65535) m_cnt++;
      if (fl) m_valid = 0;
      else if (v && exp_rdy) begin m_ins = i; m_valid = 1; end
      else if (m_valid && er) m_valid = 0;
    end
    @(negedge clk);
    if (chk) check_outputs();
  endtask

  vec_t   tbl[11];
  instr_t nop, dep, ld;
  int     snap;

  initial begin
    m_valid = 0; m_ins = '0; m_cnt = 0;
    nop = mk(32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #2;
    cycle(nop, 0, 1, 0, 1, 1);
    cycle(nop, 0, 1, 0, 1, 1);

    tbl[0]  = mkv(mk(32'h00, 5'd2, 5'd3, 5'd1, 1, 1, 1, 0), 1, 1, 1, 1, 32'h00, 1, 0);
    tbl[1]  = mkv(mk(32'h04, 5'd2, 5'd3, 5'd2, 1, 1, 1, 0), 1, 1, 1, 1, 32'h04, 1, 0);
    tbl[2]  = mkv(mk(32'h08, 5'd2, 5'd3, 5'd3, 1, 1, 1, 0), 1, 1, 1, 1, 32'h08, 1, 0);
    tbl[3]  = mkv(mk(32'h0C, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1), 1, 1, 1, 1, 32'h0C, 1, 0);
    tbl[4]  = mkv(mk(32'h10, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0), 1, 1, 0, 0, 32'h0C, 0, 1);
    tbl[5]  = mkv(mk(32'h10, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0), 1, 1, 1, 1, 32'h10, 1, 1);
    tbl[6]  = mkv(mk(32'h14, 5'd1, 5'd0, 5'd0, 1, 0, 1, 1), 1, 1, 1, 1, 32'h14, 1, 1);
    tbl[7]  = mkv(mk(32'h18, 5'd0, 5'd0, 5'd7, 1, 1, 1, 0), 1, 1, 1, 1, 32'h18, 1, 1);
    tbl[8]  = mkv(mk(32'h1C, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1), 1, 1, 1, 1, 32'h1C, 1, 1);
    tbl[9]  = mkv(mk(32'h20, 5'd1, 5'd5, 5'd8, 1, 0, 1, 0), 1, 1, 1, 1, 32'h20, 1, 1);
    tbl[10] = mkv(nop, 0, 1, 1, 0, 32'h20, 0, 1);
    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].ins, tbl[k].v, tbl[k].er, 0, 0, 1);
      check($sformatf("tbl%0d_rdy", k), 64'(seen_rdy), 64'(tbl[k].exp_rdy));
      check($sformatf("tbl%0d_valid", k), 64'(bus.ex_valid), 64'(tbl[k].exp_valid));
      check($sformatf("tbl%0d_pc", k), 64'(bus.ex_pc), 64'(tbl[k].exp_pc));
      check($sformatf("tbl%0d_rw", k), 64'(bus.ex_reg_write), 64'(tbl[k].exp_rw));
      check($sformatf("tbl%0d_cnt", k), 64'(bus.load_use_stalls), 64'(tbl[k].exp_cnt));
    end

    // Backpressure: EX holds for three cycles, then the waiting instruction loads on the release edge.
    cycle(mk(32'h100, 5'd1, 5'd2, 5'd9, 1, 1, 1, 0), 1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(mk(32'h104, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0), 1, 0, 0, 0, 1);
      check("bp_rdy", 64'(seen_rdy), 64'd0);
      check("bp_pc_hold", 64'(bus.ex_pc), 64'h100);
    end
    cycle(mk(32'h104, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0), 1, 1, 0, 0, 1);
    check("bp_release_rdy", 64'(seen_rdy), 64'd1);
    check("bp_release_pc", 64'(bus.ex_pc), 64'h104);

    // Flush wins over a load-use hazard and does not count as a stall.
    cycle(mk(32'h200, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1), 1, 1, 0, 0, 1);
    dep = mk(32'h204, 5'd5, 5'd0, 5'd11, 1, 0, 1, 0);
    snap = m_cnt;
    cycle(dep, 1, 0, 1, 0, 1);
    check("fl_rdy", 64'(seen_rdy), 64'd0);
    check("fl_valid", 64'(bus.ex_valid), 64'd0);
    check("fl_cnt", 64'(bus.load_use_stalls), 64'(snap));
    cycle(dep, 1, 1, 0, 0, 1);
    check("fl_after_rdy", 64'(seen_rdy), 64'd1);

    // Reset in the middle of a stall drops the EX instruction.
    cycle(mk(32'h300, 5'd1, 5'd0, 5'd6, 1, 0, 1, 1), 1, 1, 0, 0, 1);
    dep = mk(32'h304, 5'd1, 5'd6, 5'd12, 0, 1, 1, 0);
    cycle(dep, 1, 0, 0, 0, 1);
    check("rs_stall_rdy", 64'(seen_rdy), 64'd0);
    cycle(dep, 1, 1, 1, 1, 1);
    check("rs_valid", 64'(bus.ex_valid), 64'd0);
    check("rs_pc", 64'(bus.ex_pc), 64'd0);
    check("rs_cnt", 64'(bus.load_use_stalls), 64'd0);
    cycle(dep, 0, 1, 0, 0, 1);
    check("rs_after_rdy", 64'(seen_rdy), 64'd1);

    // Saturation: hold a dependent instruction behind a stalled load well past 65535 cycles.
    ld  = mk(32'h400, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    dep = mk(32'h404, 5'd5, 5'd5, 5'd13, 1, 1, 1, 0);
    cycle(ld, 1, 1, 0, 0, 1);
    for (int k = 0; k < 65534; k++) cycle(dep, 1, 0, 0, 0, 0);
    check("sat_fffe", 64'(bus.load_use_stalls), 64'hFFFE);
    for (int k = 0; k < 4; k++) begin
      cycle(dep, 1, 0, 0, 0, 1);
      check("sat_ffff", 64'(bus.load_use_stalls), 64'hFFFF);
    end
    cycle(dep, 1, 1, 0, 1, 1);
    check("sat_rst_cnt", 64'(bus.load_use_stalls), 64'd0);
    check("sat_rst_ctrl", 64'({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read}), 64'd0);

    // Random traffic over a small register set so hazards occur often.
    for (int k = 0; k < 3000; k++) begin
      instr_t ri;
      ri.pc = $urandom; ri.rs1_data = $urandom; ri.rs2_data = $urandom; ri.imm = $urandom;
      ri.rs1 = 5'($urandom_range(0, 7)); ri.rs2 = 5'($urandom_range(0, 7)); ri.rd = 5'($urandom_range(0, 7));
      ri.use1 = 1'($urandom); ri.use2 = 1'($urandom); ri.alu_op = 4'($urandom);
      ri.rw = 1'($urandom); ri.mr = ($urandom_range(0, 2) == 0); ri.mw = 1'($urandom); ri.mtr = 1'($urandom);
      cycle(ri, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
